tx_block_scheduler: RTL

- Sequences the 128b/130b encoder input, one 128-bit block per enabled cycle.
- Arbitrates among periodic SKP ordered-set insertion, LTSSM-requested ordered sets (TS1/TS2/EIEOS payloads) and link-layer data blocks.
- Drives the encoder's data_in, block_type and valid_in; sits between the link layer/LTSSM and the encoder.

---
 rtl/tx_block_scheduler.sv | 126 ++++++++++++
 1 files changed

// File: rtl/tx_block_scheduler.sv
// 128b/130b block scheduler: SKP > ordered set > data in IDLE, data only in STREAM; SKP insertion under `TX_SKP_INSERT_EN.
// Selection registered to enc_* one cycle later; data_ready is combinational and drops while SKP/OS is due outside a stream.
module tx_block_scheduler #(
   parameter int SKP_INTERVAL = 370,
   parameter int SKP_CNT_W    = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         tx_en,
   input  logic [127:0] data_in,
   input  logic         data_valid,
   input  logic         data_last,
   output logic         data_ready,
   input  logic         os_req,
   input  logic [127:0] os_payload,
   output logic         os_ack,
   output logic [127:0] enc_data,
   output logic         enc_block_type,
   output logic         enc_valid,
   output logic         skp_pending,
   output logic         in_stream
);

   localparam logic [127:0] SKP_BLOCK = 128'h000000E1_AAAAAAAA_AAAAAAAA_AAAAAAAA;

   if (SKP_INTERVAL < 2 || SKP_INTERVAL > (2 ** SKP_CNT_W) - 1) begin : g_bad_cfg
      $error("tx_block_scheduler: SKP_INTERVAL must lie in [2, 2**SKP_CNT_W-1]");
   end

   typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

   state_t state, state_nxt;
   logic   sel_skp, sel_os, sel_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // os_ack high means the request still visible this cycle was already served.
   always_comb begin
      state_nxt  = state;
      sel_skp    = 1'b0;
      sel_os     = 1'b0;
      sel_data   = 1'b0;
      data_ready = 1'b0;
      if (tx_en) begin
         case (state)
            IDLE: begin
               data_ready = !skp_pending && !os_req;
               if (skp_pending) begin
                  sel_skp = 1'b1;
               end else if (os_req) begin
                  sel_os = !os_ack;
               end else if (data_valid) begin
                  sel_data = 1'b1;
                  if (!data_last) state_nxt = STREAM;
               end
            end
            STREAM: begin
               data_ready = 1'b1;
               if (data_valid) begin
                  sel_data = 1'b1;
                  if (data_last) state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign in_stream = (state == STREAM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enc_data       <= '0;
         enc_block_type <= 1'b0;
         enc_valid      <= 1'b0;
         os_ack         <= 1'b0;
      end else begin
         enc_valid <= sel_skp || sel_os || sel_data;
         os_ack    <= sel_os;
         if (sel_skp) begin
            enc_data       <= SKP_BLOCK;
            enc_block_type <= 1'b1;
         end else if (sel_os) begin
            enc_data       <= os_payload;
            enc_block_type <= 1'b1;
         end else if (sel_data) begin
            enc_data       <= data_in;
            enc_block_type <= 1'b0;
         end
      end
   end

`ifdef TX_SKP_INSERT_EN
   localparam logic [SKP_CNT_W-1:0] SKP_LIMIT = SKP_CNT_W'(SKP_INTERVAL);

   logic [SKP_CNT_W-1:0] skp_cnt, skp_cnt_nxt;
   logic                 skp_pending_r;

   // Saturation keeps a long stream from queueing more than one SKP.
   always_comb begin
      skp_cnt_nxt = skp_cnt;
      if (sel_skp)
         skp_cnt_nxt = '0;
      else if ((sel_os || sel_data) && skp_cnt != SKP_LIMIT)
         skp_cnt_nxt = skp_cnt + SKP_CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skp_cnt       <= '0;
         skp_pending_r <= 1'b0;
      end else begin
         skp_cnt       <= skp_cnt_nxt;
         skp_pending_r <= (skp_cnt_nxt == SKP_LIMIT);
      end
   end

   assign skp_pending = skp_pending_r;
`else
   assign skp_pending = 1'b0;
`endif

endmodule
